// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared constants and types for the 16-bit shift/rotate controller.
//   WIDTH    : operand/result width
//   SHAMT_W  : shift amount width
//   cmd_t    : command record latched into the operand stage
//   occ_t    : result FIFO occupancy state
// ---------------------------------------------------------------------------
package shift_pkg;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;

    typedef struct packed {
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] shift;
        logic               dir;   // 0 = left, 1 = right
        logic               rot;   // 0 = logical shift, 1 = rotate
    } cmd_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

endpackage

// File: rtl/shift_ctrl_16b_shifter.sv
// ---------------------------------------------------------------------------
// shifter_16b_top
// Purely combinational 16-bit shifter/rotator.
//   x     : operand
//   shift : amount 0..15 (0 passes x unchanged in every mode)
//   dir   : 0 = left, 1 = right
//   rot   : 0 = logical (zero fill), 1 = rotate
//   out   : result
// ---------------------------------------------------------------------------
module shifter_16b_top
    import shift_pkg::*;
(
    output logic [WIDTH-1:0]   out,
    input  logic [WIDTH-1:0]   x,
    input  logic [SHAMT_W-1:0] shift,
    input  logic               dir,
    input  logic               rot
);

    // Rotates are taken from a doubled operand so n = 0 needs no special case.
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] dbl_l;
    logic [2*WIDTH-1:0] dbl_r;

    always_comb begin
        dbl   = {x, x};
        dbl_l = dbl << shift;
        dbl_r = dbl >> shift;
        out   = '0;
        case ({rot, dir})
            2'b00:   out = x << shift;
            2'b01:   out = x >> shift;
            2'b10:   out = dbl_l[2*WIDTH-1:WIDTH];
            default: out = dbl_r[WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/shift_ctrl_16b.sv
// ---------------------------------------------------------------------------
// shift_ctrl_16b
// Command -> operand stage -> shifter -> result FIFO (DEPTH entries).
// Acceptance latches the command; the next edge writes the shifted result
// into the FIFO, so out_valid follows acceptance by two edges when empty.
//
// Occupancy FSM:
//   state   | meaning
//   EMPTY   | no results held, out_valid = 0
//   PARTIAL | 0 < count < DEPTH
//   FULL    | count = DEPTH
//
// Ports:
//   clk, rst              : clock, async active-high reset
//   in_valid/in_ready     : command handshake
//   in_data/in_shift/in_dir/in_rot : command fields
//   out_valid/out_ready   : result handshake
//   out_data              : result at FIFO head (0 when empty)
//   op_count              : results delivered since reset, wraps at 16 bits
// ---------------------------------------------------------------------------
module shift_ctrl_16b
    import shift_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shift,
    input  logic               in_dir,
    input  logic               in_rot,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [15:0]        op_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);

    cmd_t             stage_q;
    logic             stage_valid;
    logic             rdy_en;
    logic [WIDTH-1:0] shift_res;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_d;
    occ_t             state_q;
    occ_t             state_d;
    logic [15:0]      op_cnt_q;
    logic             accept;
    logic             push;
    logic             pop;

    // rdy_en holds in_ready low through reset and the first edge after it.
    assign in_ready  = rdy_en && (({1'b0, fifo_count} + {{CNT_W{1'b0}}, stage_valid}) < DEPTH_C);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign push      = stage_valid;
    assign pop       = out_valid && out_ready;
    assign op_count  = op_cnt_q;

    shifter_16b_top u_shifter (
        .out   (shift_res),
        .x     (stage_q.data),
        .shift (stage_q.shift),
        .dir   (stage_q.dir),
        .rot   (stage_q.rot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en      <= 1'b0;
            stage_valid <= 1'b0;
            stage_q     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            state_q     <= OCC_EMPTY;
            op_cnt_q    <= '0;
        end else begin
            rdy_en      <= 1'b1;
            // The stage always drains into the FIFO the following edge.
            stage_valid <= accept;
            if (accept) begin
                stage_q <= '{data: in_data, shift: in_shift, dir: in_dir, rot: in_rot};
            end
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
                op_cnt_q <= op_cnt_q + 16'd1;
            end
            fifo_count <= count_d;
            state_q    <= state_d;
        end
    end

    // Storage needs no reset; out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shift_res;
        end
    end

    always_comb begin
        count_d = fifo_count;
        state_d = state_q;
        case ({push, pop})
            2'b10:   count_d = fifo_count + CNT_ONE;
            2'b01:   count_d = fifo_count - CNT_ONE;
            default: count_d = fifo_count;
        endcase
        case (state_q)
            OCC_EMPTY: begin
                if (push) begin
                    state_d = OCC_PARTIAL;
                end
            end
            OCC_PARTIAL: begin
                if (push && !pop && (fifo_count + CNT_ONE == CNT_MAX)) begin
                    state_d = OCC_FULL;
                end else if (pop && !push && (fifo_count == CNT_ONE)) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop && !push) begin
                    state_d = OCC_PARTIAL;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

endmodule
